// File: rtl/hps_adc_capture_ctrl.sv
// ADC capture controller: CSR-armed, optionally trigger-started sample capture
// with decimation, downstream FIFO occupancy tracking and overflow detection.
module hps_adc_capture_ctrl #(
    parameter int FIFO_DEPTH = 128,
    parameter int CNT_W      = 16
) (
    input  logic        wrclock,
    input  logic        reset_n,
    input  logic [1:0]  csr_address,
    input  logic        csr_write,
    input  logic        csr_read,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    input  logic [31:0] adc_data,
    input  logic        adc_valid,
    input  logic        trig,
    input  logic        fifo_rd,
    output logic [31:0] src_data,
    output logic        src_valid,
    output logic        irq
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_NSAMP  = 2'd1;
    localparam logic [1:0] ADDR_DECIM  = 2'd2;

    localparam int B_START = 0;
    localparam int B_ABORT = 1;
    localparam int B_EXT   = 2;
    localparam int B_CLR   = 3;
    localparam int B_IRQEN = 4;

    localparam logic [31:0]    CTRL_STROBES = 32'h0000_000B;
    localparam logic [LVL_W:0] DEPTH_C      = (LVL_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  nsamp_q, nsamp_d;
    logic [CNT_W-1:0]  decim_q, decim_d;
    logic [CNT_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0]  wcount_q, wcount_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              trig_q;
    logic              src_valid_q, src_valid_d;
    logic [31:0]       src_data_q, src_data_d;
    logic              irq_q, irq_d;

    logic              ctrl_wr;
    logic              abort;
    logic              start;
    logic              irq_clr;
    logic              trig_rise;
    logic              due;
    logic              full;
    logic              issue;
    logic              last_word;
    logic              pop;
    logic [LVL_W:0]    occupancy;
    logic              unused_rd;

    assign unused_rd = csr_read;

    assign ctrl_wr   = csr_write && (csr_address == ADDR_CTRL);
    assign abort     = ctrl_wr && csr_writedata[B_ABORT];
    assign start     = ctrl_wr && csr_writedata[B_START] && !abort && (state_q == IDLE);
    assign irq_clr   = ctrl_wr && csr_writedata[B_CLR];
    assign trig_rise = trig && !trig_q;

    // Occupancy counts the word already issued on src_valid but not yet in level_q.
    assign occupancy = {1'b0, level_q} + {{LVL_W{1'b0}}, src_valid_q};
    assign full      = (occupancy >= DEPTH_C);
    assign due       = (state_q == CAPTURE) && adc_valid && (phase_q == decim_q) && !abort;
    assign issue     = due && !full;
    assign last_word = issue && ((wcount_q + CNT_W'(1)) == nsamp_q);
    assign pop       = fifo_rd && (level_q != '0);

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        nsamp_d     = nsamp_q;
        decim_d     = decim_q;
        phase_d     = phase_q;
        wcount_d    = wcount_q;
        level_d     = level_q;
        ovf_d       = ovf_q;
        src_valid_d = 1'b0;
        src_data_d  = src_data_q;

        if (ctrl_wr) begin
            ctrl_d = csr_writedata & ~CTRL_STROBES;
        end
        if (csr_write && (state_q == IDLE)) begin
            if (csr_address == ADDR_NSAMP) begin
                nsamp_d = csr_writedata[CNT_W-1:0];
            end
            if (csr_address == ADDR_DECIM) begin
                decim_d = csr_writedata[CNT_W-1:0];
            end
        end

        if ((state_q == CAPTURE) && adc_valid) begin
            phase_d = (phase_q == decim_q) ? '0 : phase_q + CNT_W'(1);
        end
        if (issue) begin
            src_valid_d = 1'b1;
            src_data_d  = adc_data;
            wcount_d    = wcount_q + CNT_W'(1);
        end
        if (due && full) begin
            ovf_d = 1'b1;
        end

        if (src_valid_q && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!src_valid_q && pop) begin
            level_d = level_q - LVL_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) state_d = ARMED;
            end
            ARMED: begin
                if (nsamp_q == '0) begin
                    state_d = DONE;
                end else if (!ctrl_q[B_EXT] || trig_rise) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (last_word) state_d = DONE;
            end
            DONE: begin
                if (irq_clr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            wcount_d = '0;
            phase_d  = '0;
            ovf_d    = 1'b0;
        end
        if (abort) begin
            state_d = IDLE;
        end
    end

    // irq is registered from next-state values so it tracks DONE with no extra lag.
    assign irq_d = (state_d == DONE) && ctrl_d[B_IRQEN];

    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            nsamp_q     <= '0;
            decim_q     <= '0;
            phase_q     <= '0;
            wcount_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            trig_q      <= 1'b0;
            src_valid_q <= 1'b0;
            src_data_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            nsamp_q     <= nsamp_d;
            decim_q     <= decim_d;
            phase_q     <= phase_d;
            wcount_q    <= wcount_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            trig_q      <= trig;
            src_valid_q <= src_valid_d;
            src_data_q  <= src_data_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        csr_readdata = '0;
        case (csr_address)
            ADDR_CTRL:  csr_readdata = ctrl_q;
            ADDR_NSAMP: csr_readdata = 32'(nsamp_q);
            ADDR_DECIM: csr_readdata = 32'(decim_q);
            default: begin
                csr_readdata[1:0]   = state_q;
                csr_readdata[2]     = ovf_q;
                csr_readdata[15:8]  = 8'(level_q);
                csr_readdata[31:16] = 16'(wcount_q);
            end
        endcase
    end

    assign src_valid = src_valid_q;
    assign src_data  = src_data_q;
    assign irq       = irq_q;

endmodule
